// File: rtl/fpu_arbiter_if.sv
// Request, fpu and response signals between two issuers, the arbiter and the shared fpu.
// The arbiter uses the slave modport; the requesters and fpu sit on the master side.
interface fpu_arbiter_if #(
  parameter int TAG_W = 4
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [63:0]      req0_a;
  logic [63:0]      req0_b;
  logic             req0_double;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [63:0]      req1_a;
  logic [63:0]      req1_b;
  logic             req1_double;
  logic [TAG_W-1:0] req1_tag;

  logic [63:0]      fpu_a;
  logic [63:0]      fpu_b;
  logic             fpu_double;
  logic [63:0]      fpu_result;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [63:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_double, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_double, req1_tag,
    input  fpu_result, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, fpu_a, fpu_b, fpu_double,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_tag, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_double, req0_tag,
    output req1_valid, req1_a, req1_b, req1_double, req1_tag,
    output fpu_result, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, fpu_a, fpu_b, fpu_double,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_tag, busy
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Two-port arbiter in front of one combinational fpu adder; one operation in flight.
//   state | meaning
//   IDLE  | waiting for a request; grant alternates on ties
//   EXEC  | operands held on the fpu for LATENCY cycles
//   RESP  | result/tag held until the owning port takes it
module fpu_arbiter #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fpu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             ready0, ready1;
  logic             rsp0, rsp1;
  logic             rsp_fire;
  logic [63:0]      a_q, b_q, result_q;
  logic             double_q;
  logic [TAG_W-1:0] tag_q, rsp_tag_q;

  // On a tie the port that did not complete last wins; a lone request always wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
  end

  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    rsp0      = 1'b0;
    rsp1      = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        ready0 = rst_n && !grant && bus.req0_valid;
        ready1 = rst_n &&  grant && bus.req1_valid;
        if (ready0 || ready1) state_nxt = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp0     = !owner;
        rsp1     = owner;
        rsp_fire = owner ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      double_q   <= 1'b0;
      tag_q      <= '0;
      result_q   <= '0;
      rsp_tag_q  <= '0;
    end else begin
      state <= state_nxt;
      if (ready0 || ready1) begin
        a_q      <= grant ? bus.req1_a      : bus.req0_a;
        b_q      <= grant ? bus.req1_b      : bus.req0_b;
        double_q <= grant ? bus.req1_double : bus.req0_double;
        tag_q    <= grant ? bus.req1_tag    : bus.req0_tag;
        owner    <= grant;
        cnt      <= 4'(LATENCY - 1);
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          result_q  <= bus.fpu_result;
          rsp_tag_q <= tag_q;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      // Fairness history moves only when a response is consumed.
      if (rsp_fire) last_grant <= owner;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.fpu_a      = a_q;
  assign bus.fpu_b      = b_q;
  assign bus.fpu_double = double_q;
  assign bus.rsp0_valid = rsp0;
  assign bus.rsp1_valid = rsp1;
  assign bus.rsp_result = result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one fpu instance (single/double adder, 64-bit operands, `double` mode select) between two requesters.
- Uses valid/ready handshakes on the request and response sides.
- Captures the granted request's operands and holds them stable into the fpu for a fixed settle window, then registers the result and returns it, with a tag, to the requester that owns it.
- Sits between the issue logic and the fpu datapath. Only one operation is in flight at a time.

Parameters:
- LATENCY, 2: cycles from operand capture to result capture; legal range 1..15. Covers fpu combinational settle time.
- TAG_W, 4: width of the requester-supplied tag returned with the result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle when high together with req0_valid.
- req0_a  in  64  port 0 operand A.
- req0_b  in  64  port 0 operand B.
- req0_double  in  1  port 0 mode: 1 = double, 0 = single (operands in [31:0]).
- req0_tag  in  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_double, req1_tag: same as port 0, for port 1.
- fpu_a  out  64  operand A to the fpu.
- fpu_b  out  64  operand B to the fpu.
- fpu_double  out  1  mode to the fpu.
- fpu_result  in  64  fpu Result.
- rsp0_valid  out  1  response pending for port 0.
- rsp0_ready  in  1  port 0 consumes the response.
- rsp1_valid  out  1  response pending for port 1.
- rsp1_ready  in  1  port 1 consumes the response.
- rsp_result  out  64  registered result, shared by both ports.
- rsp_tag  out  TAG_W  tag of the request that produced rsp_result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0; operand/mode/tag/owner registers 0; cnt=0; last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - Only one port valid: grant that port.
  - Both valid: grant the port != last_grant.
  - reqN_ready = (state==IDLE) && (grant==N) && reqN_valid. The non-granted port's ready is 0.
- IDLE, on an accepted handshake:
  - Register a, b, double, tag and owner=grant.
  - Set cnt=LATENCY-1 and go to EXEC.
  - Neither port valid: stay in IDLE.
- EXEC:
  - fpu_a/fpu_b/fpu_double are driven from the registered operands and are stable for the whole window.
  - At each edge: if cnt==0, capture fpu_result into rsp_result and go to RESP; otherwise cnt decrements.
  - EXEC lasts exactly LATENCY cycles.
- RESP:
  - rsp<owner>_valid=1; the other port's rsp_valid stays 0.
  - rsp_result and rsp_tag are held stable until rsp<owner>_ready=1.
  - On that edge: last_grant=owner, rsp_valid drops, go to IDLE.
- Backpressure: ready on the non-owner port has no effect. A stalled response blocks both ports; no new request is accepted outside IDLE.
- Timing from acceptance at edge E0:
  - rsp_valid is high in the cycle after edge E0+LATENCY.
  - Best-case back-to-back issue interval is LATENCY+2 cycles.
- Result width: captured verbatim. In single mode the fpu already zero-fills [63:32]; the block does not alter it.
- Operand registers are not cleared between operations. fpu inputs are don't-care while in IDLE.
- Requesters must hold a, b, double and tag stable while valid=1 and ready=0. The block does not check this.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped and its result never appears. After rst_n rises, the block behaves exactly as after power-up.
- last_grant changes only on response completion, never on acceptance.

Test Plan:
- Port 0 only, LATENCY=2: a=0x3FF0000000000000, b=0x4000000000000000, double=1, tag=3 -> req0_ready high for 1 cycle; rsp0_valid rises 3 cycles after acceptance; rsp_result=0x4008000000000000, rsp_tag=3; rsp1_valid stays 0.
- Port 1 single mode: a=0x3F800000, b=0x40000000, double=0, tag=5 -> rsp1_valid; rsp_result=0x0000000040400000, rsp_tag=5.
- Both ports held valid continuously from reset, rsp ready tied 1 -> grant order 0,1,0,1; each completes in order with its own tag; the other port's ready is never high during a grant.
- Backpressure: hold rsp0_ready=0 for 5 cycles after rsp0_valid -> rsp_result/rsp_tag stable, busy=1, req0_ready and req1_ready stay 0; release -> IDLE next cycle and port 1 is granted next.
- Reset pulse during EXEC (tag=7) -> all outputs 0 immediately; after release, a new request with tag=2 completes normally and tag 7 never appears.
- LATENCY=1 build -> rsp_valid rises 2 cycles after acceptance with the correct sum.
